// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - MMIO register map and field positions shared by the data-side responder
package cpu_pkg;

    localparam logic [7:0] MMIO_CYCLE = 8'h00;
    localparam logic [7:0] MMIO_TCMP  = 8'h04;
    localparam logic [7:0] MMIO_TCTRL = 8'h08;
    localparam logic [7:0] MMIO_CONTX = 8'h0C;
    localparam logic [7:0] MMIO_CONST = 8'h10;

    localparam int TCTRL_EN   = 0;
    localparam int TCTRL_PEND = 1;

    localparam int CONST_FULL      = 0;
    localparam int CONST_EMPTY     = 1;
    localparam int CONST_OVF       = 2;
    localparam int CONST_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_CYCLE,
        REG_TCMP,
        REG_TCTRL,
        REG_CONTX,
        REG_CONST
    } mmio_reg_e;

    // Only exact word offsets select a register; anything else inside the window is unmapped.
    function automatic mmio_reg_e mmio_decode(input logic [7:0] off);
        case (off)
            MMIO_CYCLE: return REG_CYCLE;
            MMIO_TCMP:  return REG_TCMP;
            MMIO_TCTRL: return REG_TCTRL;
            MMIO_CONTX: return REG_CONTX;
            MMIO_CONST: return REG_CONST;
            default:    return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; a push into a full FIFO is taken only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - CPU data port: word RAM plus cycle/timer/console MMIO window
module data_mem_responder
    import cpu_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
    parameter int          CON_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic        data_re_i,
    input  logic        data_we_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic [7:0]  con_data_o,
    output logic        con_valid_o,
    input  logic        con_ready_i,
    output logic        timer_irq_o
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam int          CW        = $clog2(CON_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);

    logic [31:0]   mem [MEM_WORDS];
    logic [31:0]   cycle_q;
    logic [31:0]   tcmp_q;
    logic          en_q;
    logic          pend_q;
    logic          ovf_q;

    logic [31:0]   mmio_off;
    logic [AW-1:0] word_idx;
    logic          ram_hit;
    logic          mmio_hit;
    mmio_reg_e     sel;
    logic          rd_ok;
    logic          wr_ok;
    logic [31:0]   con_stat;

    logic          con_push;
    logic          con_pop;
    logic          con_full;
    logic          con_empty;
    logic [CW-1:0] con_count;

    assign mmio_off = data_addr_i - MMIO_BASE;
    assign word_idx = data_addr_i[AW+1:2];
    assign ram_hit  = (data_addr_i < RAM_BYTES);
    assign mmio_hit = !ram_hit && (data_addr_i >= MMIO_BASE) && (mmio_off <= 32'h10);
    assign sel      = mmio_hit ? mmio_decode(mmio_off[7:0]) : REG_NONE;

    // Misaligned, unmapped and simultaneous read+write all suppress the access entirely.
    assign data_err_o = (data_re_i | data_we_i) &
                        ((data_addr_i[1:0] != 2'b00) | (!ram_hit && sel == REG_NONE) |
                         (data_re_i & data_we_i));
    assign rd_ok = data_re_i & ~data_err_o;
    assign wr_ok = data_we_i & ~data_err_o;

    assign con_push    = wr_ok && (sel == REG_CONTX);
    assign con_pop     = con_ready_i & ~con_empty;
    assign con_valid_o = ~con_empty;

    always_comb begin
        con_stat                            = '0;
        con_stat[CONST_FULL]                = con_full;
        con_stat[CONST_EMPTY]               = con_empty;
        con_stat[CONST_OVF]                 = ovf_q;
        con_stat[CONST_COUNT_LSB +: 4]      = 4'(con_count);
    end

    always_comb begin
        data_rdata_o = '0;
        if (rd_ok) begin
            if (ram_hit) begin
                data_rdata_o = mem[word_idx];
            end else begin
                case (sel)
                    REG_CYCLE: data_rdata_o = cycle_q;
                    REG_TCMP:  data_rdata_o = tcmp_q;
                    REG_TCTRL: data_rdata_o = {30'b0, pend_q, en_q};
                    REG_CONST: data_rdata_o = con_stat;
                    default:   data_rdata_o = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok && ram_hit && !reset_i) begin
            mem[word_idx] <= data_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cycle_q     <= '0;
            tcmp_q      <= '0;
            en_q        <= 1'b0;
            pend_q      <= 1'b0;
            ovf_q       <= 1'b0;
            timer_irq_o <= 1'b0;
        end else begin
            cycle_q     <= cycle_q + 32'd1;
            timer_irq_o <= pend_q & en_q;
            if (wr_ok && sel == REG_TCMP) begin
                tcmp_q <= data_wdata_i;
            end
            if (wr_ok && sel == REG_TCTRL) begin
                en_q <= data_wdata_i[TCTRL_EN];
                if (data_wdata_i[TCTRL_PEND]) pend_q <= 1'b0;
            end
            // Placed after the W1C so a compare hit in the same cycle keeps PEND set.
            if (en_q && cycle_q == tcmp_q) begin
                pend_q <= 1'b1;
            end
            if (con_push && con_full && !con_pop) begin
                ovf_q <= 1'b1;
            end else if (wr_ok && sel == REG_CONST && data_wdata_i[CONST_OVF]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (CON_DEPTH)
    ) u_con_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push    (con_push),
        .wdata   (data_wdata_i[7:0]),
        .pop     (con_pop),
        .rdata   (con_data_o),
        .full    (con_full),
        .empty   (con_empty),
        .count   (con_count)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed and randomized checks against a queue-based reference model
module tb_data_mem_responder;

    localparam int          MEM_WORDS = 1024;
    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;
    localparam int          CON_DEPTH = 8;

    localparam logic [31:0] A_CYCLE = MMIO_BASE + 32'h00;
    localparam logic [31:0] A_TCMP  = MMIO_BASE + 32'h04;
    localparam logic [31:0] A_TCTRL = MMIO_BASE + 32'h08;
    localparam logic [31:0] A_CONTX = MMIO_BASE + 32'h0C;
    localparam logic [31:0] A_CONST = MMIO_BASE + 32'h10;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_re_i;
    logic        data_we_i;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic [7:0]  con_data_o;
    logic        con_valid_o;
    logic        con_ready_i;
    logic        timer_irq_o;

    always #5 clk_i = ~clk_i;

    data_mem_responder #(
        .MEM_WORDS (MEM_WORDS),
        .MMIO_BASE (MMIO_BASE),
        .CON_DEPTH (CON_DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .data_addr_i  (data_addr_i),
        .data_wdata_i (data_wdata_i),
        .data_re_i    (data_re_i),
        .data_we_i    (data_we_i),
        .data_rdata_o (data_rdata_o),
        .data_err_o   (data_err_o),
        .con_data_o   (con_data_o),
        .con_valid_o  (con_valid_o),
        .con_ready_i  (con_ready_i),
        .timer_irq_o  (timer_irq_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [31:0] m_ram    [MEM_WORDS];
    bit          m_ram_ok [MEM_WORDS];
    logic [31:0] m_cycle;
    logic [31:0] m_cmp;
    bit          m_en, m_pend, m_ovf, m_irq;
    logic [7:0]  m_q [$];

    logic [31:0] last_rdata;
    logic        last_err;
    logic        last_valid;
    logic [7:0]  last_data;

    // -1 illegal, 0..4 MMIO register index, 5 RAM
    function automatic int region(input logic [31:0] a);
        if (a % 4 != 0) return -1;
        if (a < 4 * MEM_WORDS) return 5;
        if (a >= MMIO_BASE && a - MMIO_BASE <= 16) return int'((a - MMIO_BASE) / 4);
        return -1;
    endfunction

    task automatic model_reset();
        m_cycle = 0; m_cmp = 0; m_en = 0; m_pend = 0; m_ovf = 0; m_irq = 0;
        m_q.delete();
    endtask

    task automatic model_expect(output logic [31:0] rd, output bit err, output bit known);
        int r;
        int n;
        r     = region(data_addr_i);
        err   = (data_re_i || data_we_i) && (r < 0 || (data_re_i && data_we_i));
        rd    = 0;
        known = 1;
        n     = m_q.size();
        if (data_re_i && !err) begin
            case (r)
                5: begin
                    known = m_ram_ok[int'(data_addr_i / 4)];
                    rd    = m_ram[int'(data_addr_i / 4)];
                end
                0: rd = m_cycle;
                1: rd = m_cmp;
                2: rd = {30'b0, m_pend, m_en};
                4: rd = {20'b0, 4'(n), 5'b0, m_ovf, (n == 0), (n == CON_DEPTH)};
                default: rd = 0;
            endcase
        end
    endtask

    task automatic model_step();
        int r;
        bit err, wr, set_p;
        r   = region(data_addr_i);
        err = (data_re_i || data_we_i) && (r < 0 || (data_re_i && data_we_i));
        wr  = data_we_i && !err;
        if (reset_i) begin
            model_reset();
            return;
        end
        set_p = m_en && (m_cycle == m_cmp);
        m_irq = m_pend && m_en;
        if (con_ready_i && m_q.size() > 0) void'(m_q.pop_front());
        if (wr) begin
            case (r)
                5: begin
                    m_ram[int'(data_addr_i / 4)]    = data_wdata_i;
                    m_ram_ok[int'(data_addr_i / 4)] = 1;
                end
                1: m_cmp = data_wdata_i;
                2: begin
                    m_en = data_wdata_i[0];
                    if (data_wdata_i[1]) m_pend = 0;
                end
                3: begin
                    if (m_q.size() < CON_DEPTH) m_q.push_back(data_wdata_i[7:0]);
                    else m_ovf = 1;
                end
                4: if (data_wdata_i[2]) m_ovf = 0;
                default: ;
            endcase
        end
        if (set_p) m_pend = 1;
        m_cycle = m_cycle + 1;
    endtask

    task automatic do_cycle(input bit rst, input logic [31:0] a, input logic [31:0] wd,
                            input bit re, input bit we, input bit rdy);
        logic [31:0] erd;
        bit          eerr, known;
        reset_i      = rst;
        data_addr_i  = a;
        data_wdata_i = wd;
        data_re_i    = re;
        data_we_i    = we;
        con_ready_i  = rdy;
        #1;
        model_expect(erd, eerr, known);
        check_eq("err", {31'b0, data_err_o}, {31'b0, eerr});
        if (known) check_eq("rdata", data_rdata_o, erd);
        check_eq("con_valid", {31'b0, con_valid_o}, {31'b0, (m_q.size() > 0)});
        if (m_q.size() > 0) check_eq("con_data", {24'b0, con_data_o}, {24'b0, m_q[0]});
        check_eq("timer_irq", {31'b0, timer_irq_o}, {31'b0, m_irq});
        last_rdata = data_rdata_o;
        last_err   = data_err_o;
        last_valid = con_valid_o;
        last_data  = con_data_o;
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input bit rdy);
        do_cycle(0, a, 32'h0, 1, 0, rdy);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd, input bit rdy);
        do_cycle(0, a, wd, 0, 1, rdy);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1; data_addr_i = 0; data_wdata_i = 0;
        data_re_i = 0; data_we_i = 0; con_ready_i = 0;
        repeat (2) @(posedge clk_i);
        model_reset();
        #1;

        // Reset state
        rd(A_CYCLE, 0);
        check_eq("cycle_after_reset", last_rdata, 32'h0);
        check_eq("valid_after_reset", {31'b0, last_valid}, 32'h0);

        // RAM write then readback
        wr(32'h40, 32'hDEADBEEF, 0);
        rd(32'h40, 0);
        check_eq("ram_readback", last_rdata, 32'hDEADBEEF);
        check_eq("ram_readback_err", {31'b0, last_err}, 32'h0);

        // Illegal accesses
        rd(32'h42, 0);
        check_eq("misaligned_err", {31'b0, last_err}, 32'h1);
        check_eq("misaligned_rdata", last_rdata, 32'h0);
        wr(32'h4000_0000, 32'h1111_1111, 0);
        check_eq("unmapped_err", {31'b0, last_err}, 32'h1);
        do_cycle(0, 32'h40, 32'h2222_2222, 1, 1, 0);
        check_eq("re_we_err", {31'b0, last_err}, 32'h1);
        rd(32'h40, 0);
        check_eq("ram_unchanged", last_rdata, 32'hDEADBEEF);

        // Timer compare
        wr(A_TCMP, 32'd20, 0);
        wr(A_TCTRL, 32'h1, 0);
        repeat (20) rd(A_TCTRL, 0);
        check_eq("tctrl_pend", last_rdata, 32'h3);
        check_eq("irq_high", {31'b0, timer_irq_o}, 32'h1);
        wr(A_TCTRL, 32'h3, 0);
        rd(A_TCTRL, 0);
        rd(A_TCTRL, 0);
        check_eq("tctrl_after_w1c", last_rdata, 32'h1);
        check_eq("irq_low", {31'b0, timer_irq_o}, 32'h0);
        wr(A_TCTRL, 32'h0, 0);

        // Console overflow and drain order
        for (int i = 0; i < 9; i++) wr(A_CONTX, 32'h41 + i, 0);
        rd(A_CONST, 0);
        check_eq("const_full_ovf", last_rdata, 32'h805);
        for (int i = 0; i < 8; i++) begin
            do_cycle(0, 32'h0, 32'h0, 0, 0, 1);
            check_eq("drain_valid", {31'b0, last_valid}, 32'h1);
            check_eq("drain_order", {24'b0, last_data}, 32'h41 + i);
        end
        rd(A_CONST, 0);
        check_eq("const_empty_ovf", last_rdata, 32'h006);

        // Push and pop together while full
        wr(A_CONST, 32'h4, 0);
        for (int i = 0; i < 8; i++) wr(A_CONTX, 32'h50 + i, 0);
        wr(A_CONTX, 32'h60, 1);
        rd(A_CONST, 0);
        check_eq("const_full_no_ovf", last_rdata, 32'h801);
        for (int i = 0; i < 8; i++) do_cycle(0, 32'h0, 32'h0, 0, 0, 1);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) wr(A_CONTX, 32'h70 + i, 0);
        do_cycle(1, 32'h40, 32'h1234_5678, 0, 1, 0);
        rd(A_CYCLE, 0);
        check_eq("reset_valid", {31'b0, last_valid}, 32'h0);
        check_eq("reset_cycle", last_rdata, 32'h0);
        rd(32'h40, 0);
        check_eq("reset_ram_kept", last_rdata, 32'hDEADBEEF);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            logic [31:0] wd;
            int          k;
            int          op;
            bit          re, we, rst;
            k = int'($urandom_range(0, 9));
            if (k < 4) begin
                a = 32'($urandom_range(0, 15) * 4);
                if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            end else if (k < 8) begin
                a = MMIO_BASE + 32'($urandom_range(0, 5) * 4);
                if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            end else begin
                a = $urandom;
            end
            wd = $urandom;
            if (a == A_TCMP) wd = m_cycle + 32'($urandom_range(1, 12));
            op = int'($urandom_range(0, 3));
            re = (op == 1) || (op == 3);
            we = (op == 2) || (op == 3 && $urandom_range(0, 4) == 0);
            rst = ($urandom_range(0, 199) == 0);
            do_cycle(rst, a, wd, re, we, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, giving the number of 32-bit words of data RAM at base 0x0000_0000.
REQ-002 SHALL have parameter MMIO_BASE, default 32'h8000_0000, giving the base address of the peripheral register window.
REQ-003 SHALL have parameter CON_DEPTH, default 8, giving the number of console FIFO entries (power of 2).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port data_addr_i, input, 32 bits: byte address from the CPU.
REQ-007 SHALL have port data_wdata_i, input, 32 bits: write data.
REQ-008 SHALL have port data_re_i, input, 1 bit: read request.
REQ-009 SHALL have port data_we_i, input, 1 bit: write request.
REQ-010 SHALL have port data_rdata_o, output, 32 bits: read data, combinational, valid in the same cycle as the request.
REQ-011 SHALL have port data_err_o, output, 1 bit: combinational flag for an illegal access.
REQ-012 SHALL have port con_data_o, output, 8 bits: console byte at the FIFO head.
REQ-013 SHALL have port con_valid_o, output, 1 bit: FIFO is not empty.
REQ-014 SHALL have port con_ready_i, input, 1 bit: sink accepts the byte; a pop occurs when valid and ready are both high.
REQ-015 SHALL have port timer_irq_o, output, 1 bit: timer interrupt, registered.

Function
REQ-016 SHALL decode RAM accesses as data_addr_i < 4*MEM_WORDS, using word index data_addr_i[31:2].
REQ-017 SHALL decode MMIO accesses as MMIO_BASE+0x00..0x10; every other address SHALL be unmapped.
REQ-018 SHALL assert data_err_o when (re|we) and the address is misaligned (addr[1:0]!=0), unmapped, or both re and we are high; an erroring access SHALL write nothing and return rdata 0.
REQ-019 SHALL drive data_rdata_o to 0 whenever data_re_i is low.
REQ-020 SHALL perform writes on the clock edge, so a read in the cycle after a write returns the new value.
REQ-021 SHALL implement MMIO register 0x00 CYCLE (read-only): free-running counter, +1 every cycle, wraps 0xFFFF_FFFF->0; writes to it SHALL be ignored without error.
REQ-022 SHALL implement MMIO register 0x04 TIMER_CMP (read/write).
REQ-023 SHALL implement MMIO register 0x08 TIMER_CTRL with bit0 EN (read/write) and bit1 PEND (write-1-to-clear); all other bits SHALL read 0.
REQ-024 SHALL set PEND on the edge following any cycle where EN=1 and CYCLE==TIMER_CMP; if a set and a W1C fall in the same cycle, the set SHALL win.
REQ-025 SHALL drive timer_irq_o as a register of PEND&EN.
REQ-026 SHALL implement MMIO register 0x0C CON_TX (write-only, reads 0): a write pushes data_wdata_i[7:0] into the console FIFO.
REQ-027 SHALL implement MMIO register 0x10 CON_STAT with bit0 FULL, bit1 EMPTY, bit2 OVF (sticky; writing 1 clears it), and bits[11:8] COUNT.
REQ-028 SHALL accept a push when count<CON_DEPTH, or when a pop occurs in the same cycle.
REQ-029 SHALL, when a push is rejected, drop the byte and set OVF.
REQ-030 SHALL leave count unchanged on a simultaneous push and pop.
REQ-031 SHALL ignore a pop while empty.
REQ-032 SHALL drive con_data_o as the FIFO head entry, which is don't-care while empty.

Reset
REQ-033 SHALL, when reset_i is high at a rising edge, clear CYCLE, TIMER_CMP, EN, PEND, OVF, FIFO pointers and count, and timer_irq_o to 0; con_valid_o SHALL then read 0.
REQ-034 SHALL leave RAM contents unchanged on reset.
REQ-035 SHALL, on reset mid-operation, discard FIFO contents and ignore CPU writes issued in the reset cycle.

Structure
REQ-036 SHALL place the MMIO offsets (MMIO_CYCLE, MMIO_TCMP, MMIO_TCTRL, MMIO_CONTX, MMIO_CONST) and the CON_STAT bit positions in cpu_pkg.
REQ-037 SHALL implement the console FIFO as sub-module sync_fifo, with parameters WIDTH and DEPTH and ports push/pop/full/empty/count.

Verification
REQ-038 SHALL be verified by writing 0xDEADBEEF to 0x40, then reading 0x40 the next cycle -> rdata 0xDEADBEEF, err 0.
REQ-039 SHALL be verified by reading 0x42 and by writing 0x4000_0000 -> err 1, rdata 0, RAM unchanged.
REQ-040 SHALL be verified by setting TIMER_CMP=20 and EN=1 before CYCLE reaches 20 -> PEND=1 after CYCLE=20, timer_irq_o high one cycle later; W1C to PEND -> irq low.
REQ-041 SHALL be verified by pushing 9 bytes 0x41..0x49 with con_ready_i=0 -> COUNT=8, FULL=1, OVF=1; then raising ready -> output order 0x41..0x48, EMPTY=1.
REQ-042 SHALL be verified by a push and a pop in the same cycle while full -> COUNT stays 8, OVF not set.
REQ-043 SHALL be verified by asserting reset_i for one cycle with 3 bytes queued -> con_valid_o=0, CYCLE restarts at 0, RAM word at 0x40 retained.
